// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-PC bundle between the PC unit and its neighbours
// (hazard unit stall, IF handshake, EX redirect, exception trap).
// The master modport belongs to the PC unit; slave is the surrounding pipeline.
`timescale 1ns/1ps

interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic            pipeline_stop;
    logic            if_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap_valid;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            pend_valid;
    logic            misalign;

    modport master (
        input  pipeline_stop, if_ready, redirect_valid, redirect_target, trap_valid,
        output pc, pc_valid, pend_valid, misalign
    );

    modport slave (
        output pipeline_stop, if_ready, redirect_valid, redirect_target, trap_valid,
        input  pc, pc_valid, pend_valid, misalign
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with valid/ready issue to IF, stall,
// buffered branch/jump redirect, trap vectoring and a one-cycle boot bubble.
// Optional feature macro: PC_ALIGN_CHECK_EN -- when defined, a redirect target
// (direct or buffered) that is not INC-aligned is replaced by TRAP_VEC at the
// moment it would be applied, and misalign pulses for one cycle.
`timescale 1ns/1ps

module pc_unit #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_001C,
    parameter int          INC       = 4
) (
    input logic       clk,
    input logic       rst,
    pc_unit_if.master bus
);

    localparam logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VEC);
    localparam logic [XLEN-1:0] TRAP_PC  = XLEN'(TRAP_VEC);
    localparam logic [XLEN-1:0] STEP     = XLEN'(INC);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        PEND
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_target;
    logic            pc_valid_q;
    logic            misalign_q;

    logic            fire;
    logic [XLEN-1:0] apply_target;
    logic            apply_bad;

    assign fire = pc_valid_q & bus.if_ready & ~bus.pipeline_stop;

    // Choose which target would be applied this cycle: a live redirect beats the buffered one.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        apply_target = pend_target;
        if (bus.redirect_valid) begin
            apply_target = bus.redirect_target;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
    assign apply_bad = |(apply_target & ALIGN_MASK);
`else
    assign apply_bad = 1'b0;
`endif

    // Boot/run/pend sequencing and next-pc selection, all outputs registered.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
        if (rst) begin
            state       <= BOOT;
            pc_q        <= RESET_PC;
            pend_target <= '0;
            pc_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state)
                BOOT: begin
                    // Bubble cycle: pc stays at the reset vector, request becomes valid.
                    state      <= RUN;
                    pc_valid_q <= 1'b1;
                end
                default: begin
                    if (bus.trap_valid) begin
                        pc_q  <= TRAP_PC;
                        state <= RUN;
                    end else if (bus.redirect_valid && !bus.pipeline_stop) begin
                        pc_q       <= apply_bad ? TRAP_PC : apply_target;
                        misalign_q <= apply_bad;
                        state      <= RUN;
                    end else if (bus.redirect_valid) begin
                        // Stalled: buffer the newest redirect, older one is overwritten.
                        pend_target <= bus.redirect_target;
                        state       <= PEND;
                    end else if (state == PEND && !bus.pipeline_stop) begin
                        pc_q       <= apply_bad ? TRAP_PC : apply_target;
                        misalign_q <= apply_bad;
                        state      <= RUN;
                    end else if (fire) begin
                        pc_q <= pc_q + STEP;
                    end
                end
            endcase
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_valid   = pc_valid_q;
    assign bus.pend_valid = (state == PEND);
    assign bus.misalign   = misalign_q;

endmodule
